// File: rtl/mem_delay_arbiter.sv
// Round-robin arbiter sharing one memory port, with a programmable per-requester delay before issue.
// Optional DELAY_ARB_STATS_EN adds per-requester wait-cycle counters (stat_sel_i / stat_cnt_o).
module mem_delay_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DELAY_WIDTH   = 4,
  parameter int DEFAULT_DELAY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  input  logic                          cfg_we_i,
  input  logic [$clog2(NUM_REQ)-1:0]    cfg_idx_i,
  input  logic [DELAY_WIDTH-1:0]        cfg_delay_i,
  output logic                          mem_req_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic                          mem_we_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
`ifdef DELAY_ARB_STATS_EN
  input  logic [$clog2(NUM_REQ)-1:0]    stat_sel_i,
  output logic [31:0]                   stat_cnt_o,
`endif
  output logic                          busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, DELAY, ISSUE, WAIT_RSP} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, owner_q, pick_idx, cand;
  logic                   pick_valid;
  logic [DELAY_WIDTH-1:0] cnt_q;
  logic [DELAY_WIDTH-1:0] delay_q [NUM_REQ];
  logic                   we_q;
  logic                   cfg_ok;

  assign cfg_ok = cfg_we_i && (int'(cfg_idx_i) < NUM_REQ);

  // Scan from the far end back toward ptr+1 so the nearest requester after the last owner wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_valid)
          state_d = (delay_q[pick_idx] == '0) ? ISSUE : DELAY;
      end
      DELAY: begin
        if (!req_i[owner_q])                       state_d = IDLE;
        else if (cnt_q == DELAY_WIDTH'(1))         state_d = ISSUE;
      end
      ISSUE: begin
        if (mem_gnt_i)                             state_d = WAIT_RSP;
        else if (!req_i[owner_q])                  state_d = IDLE;
      end
      WAIT_RSP: begin
        if (mem_rvalid_i)                          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs are registered off the next state so mem_req_o follows ISSUE exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      for (int k = 0; k < NUM_REQ; k++) delay_q[k] <= DELAY_WIDTH'(DEFAULT_DELAY);
    end else begin
      if (cfg_ok) delay_q[cfg_idx_i] <= cfg_delay_i;
      mem_req_o <= (state_d == ISSUE);
      mem_we_o  <= (state_d == ISSUE) && ((state_q == IDLE) ? we_i[pick_idx] : we_q);
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q     <= pick_idx;
            ptr_q       <= pick_idx;
            cnt_q       <= delay_q[pick_idx];
            we_q        <= we_i[pick_idx];
            mem_addr_o  <= addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_o <= wdata_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        DELAY: begin
          if (cnt_q != DELAY_WIDTH'(1)) cnt_q <= cnt_q - DELAY_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    rdata_o  = '0;
    busy_o   = (state_q != IDLE);
    if (state_q == ISSUE) gnt_o[owner_q] = mem_gnt_i;
    if (state_q == WAIT_RSP) begin
      rvalid_o[owner_q] = mem_rvalid_i;
      rdata_o           = mem_rdata_i;
    end
  end

`ifdef DELAY_ARB_STATS_EN
  logic [31:0] stat_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REQ; k++) stat_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++)
        if (req_i[k] && !gnt_o[k] && (stat_q[k] != 32'hFFFF_FFFF))
          stat_q[k] <= stat_q[k] + 32'd1;
    end
  end

  assign stat_cnt_o = stat_q[stat_sel_i];
`endif

endmodule

// File: tb/tb_mem_delay_arbiter.sv
// Directed bench for mem_delay_arbiter: vector table of single-requester transactions plus
// hand-written sequences for round-robin, config/load collision, abandon and mid-transaction reset.
module tb_mem_delay_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_i;
  logic [63:0] addr_i;
  logic [1:0]  we_i;
  logic [63:0] wdata_i;
  logic [1:0]  gnt_o;
  logic [1:0]  rvalid_o;
  logic [31:0] rdata_o;
  logic        cfg_we_i;
  logic        cfg_idx_i;
  logic [3:0]  cfg_delay_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
`ifdef DELAY_ARB_STATS_EN
  logic        stat_sel_i;
  logic [31:0] stat_cnt_o;
`endif

  int compared   = 0;
  int mismatched = 0;

  mem_delay_arbiter dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_delay_i(cfg_delay_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
`ifdef DELAY_ARB_STATS_EN
    .stat_sel_i(stat_sel_i), .stat_cnt_o(stat_cnt_o),
`endif
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          doCfg;
    int          idx;
    int          dly;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          expLat;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] we,
                               input logic [63:0] addr, input logic [63:0] wdata);
    req_i   = req;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wdata;
  endtask

  task automatic cfgWrite(input int idx, input int dly);
    cfg_we_i    = 1'b1;
    cfg_idx_i   = idx[0];
    cfg_delay_i = dly[3:0];
    @(negedge clk);
    cfg_we_i    = 1'b0;
  endtask

  // Called at a negedge with the request already driven; grant on first mem_req_o, response 2 cycles later.
  task automatic doTxn(input string tag, input int owner, input int expLat, input logic [31:0] expAddr,
                       input logic expWe, input logic [31:0] expWdata, input logic [31:0] rdata,
                       input bit dropReq);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 40 && !seen) begin
      @(negedge clk);
      cfg_we_i = 1'b0;
      cyc++;
      seen = mem_req_o;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s timeout: mem_req_o never rose within 40 cycles", tag);
      return;
    end
    checkOutput({tag, " latency"}, cyc, expLat);
    checkOutput({tag, " mem_addr"}, mem_addr_o, expAddr);
    checkOutput({tag, " mem_we"}, {31'd0, mem_we_o}, {31'd0, expWe});
    checkOutput({tag, " mem_wdata"}, mem_wdata_o, expWdata);
    checkOutput({tag, " gnt before mem_gnt"}, {30'd0, gnt_o}, 32'd0);
    mem_gnt_i = 1'b1;
    #1;
    checkOutput({tag, " gnt"}, {30'd0, gnt_o}, 32'd1 << owner);
    @(negedge clk);
    mem_gnt_i = 1'b0;
    if (dropReq) req_i[owner] = 1'b0;
    checkOutput({tag, " mem_req after gnt"}, {31'd0, mem_req_o}, 32'd0);
    checkOutput({tag, " busy in wait"}, {31'd0, busy_o}, 32'd1);
    @(negedge clk);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    #1;
    checkOutput({tag, " rvalid"}, {30'd0, rvalid_o}, 32'd1 << owner);
    checkOutput({tag, " rdata"}, rdata_o, rdata);
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    checkOutput({tag, " busy after rsp"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    logic [63:0] a, w;
    logic [1:0]  wv;
    bit          sawReq;

    vecs[0] = '{0, 0, 0, 32'h1000_0000, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 2};
    vecs[1] = '{1, 1, 5, 32'h2000_0004, 1'b1, 32'hCAFE_F00D, 32'h0000_1111, 6};
    vecs[2] = '{1, 0, 0, 32'h3000_0008, 1'b1, 32'h0BAD_0001, 32'h2222_0000, 1};
    vecs[3] = '{1, 0, 3, 32'h4000_000C, 1'b0, 32'h0000_0000, 32'h3333_3333, 4};
    vecs[4] = '{1, 1, 2, 32'h5000_0010, 1'b0, 32'h0000_0000, 32'h4444_4444, 3};

    rst = 1'b1; req_i = '0; addr_i = '0; we_i = '0; wdata_i = '0;
    cfg_we_i = 1'b0; cfg_idx_i = 1'b0; cfg_delay_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
`ifdef DELAY_ARB_STATS_EN
    stat_sel_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset busy", {31'd0, busy_o}, 32'd0);
    checkOutput("reset mem_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("reset mem_we", {31'd0, mem_we_o}, 32'd0);
    checkOutput("reset mem_addr", mem_addr_o, 32'd0);
    checkOutput("reset mem_wdata", mem_wdata_o, 32'd0);
    checkOutput("reset gnt/rvalid", {28'd0, gnt_o, rvalid_o}, 32'd0);
    checkOutput("reset rdata", rdata_o, 32'd0);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].doCfg) cfgWrite(vecs[i].idx, vecs[i].dly);
      a  = {2{32'hFFFF_FFF0 | 32'(i)}};
      w  = {2{32'h5A5A_5A5A}};
      wv = 2'b00;
      a[vecs[i].idx*32 +: 32] = vecs[i].addr;
      w[vecs[i].idx*32 +: 32] = vecs[i].wdata;
      wv[vecs[i].idx]         = vecs[i].we;
      applyStimulus(2'b01 << vecs[i].idx, wv, a, w);
      doTxn($sformatf("vec%0d", i), vecs[i].idx, vecs[i].expLat, vecs[i].addr,
            vecs[i].we, vecs[i].wdata, vecs[i].rdata, 1'b1);
    end

    // Both requesting continuously: last owner was 1, delays are d0=3, d1=2.
    applyStimulus(2'b11, 2'b00, {32'hB000_0001, 32'hA000_0000}, {32'h0000_0011, 32'h0000_0022});
    doTxn("rr0", 0, 4, 32'hA000_0000, 1'b0, 32'h22, 32'h1, 1'b0);
    doTxn("rr1", 1, 3, 32'hB000_0001, 1'b0, 32'h11, 32'h2, 1'b0);
    doTxn("rr2", 0, 4, 32'hA000_0000, 1'b0, 32'h22, 32'h3, 1'b0);
    doTxn("rr3", 1, 3, 32'hB000_0001, 1'b0, 32'h11, 32'h4, 1'b0);
    req_i = '0;

    // Config write on the same cycle as the load: old delay 2 applies, new delay 7 applies next time.
    cfg_we_i = 1'b1; cfg_idx_i = 1'b1; cfg_delay_i = 4'd7;
    applyStimulus(2'b10, 2'b00, {32'hC000_0000, 32'h0}, 64'd0);
    doTxn("cfgcollide old", 1, 3, 32'hC000_0000, 1'b0, 32'h0, 32'h77, 1'b1);
    applyStimulus(2'b10, 2'b00, {32'hC000_0004, 32'h0}, 64'd0);
    doTxn("cfgcollide new", 1, 8, 32'hC000_0004, 1'b0, 32'h0, 32'h78, 1'b1);

    // Abandon during DELAY (d0=3).
    applyStimulus(2'b01, 2'b00, {32'h0, 32'hD000_0000}, 64'd0);
    repeat (2) @(negedge clk);
    checkOutput("abandon delay busy", {31'd0, busy_o}, 32'd1);
    req_i = '0;
    @(negedge clk);
    checkOutput("abandon delay busy low", {31'd0, busy_o}, 32'd0);
    sawReq = mem_req_o || (gnt_o != 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sawReq = sawReq || mem_req_o || (gnt_o != 2'b00);
    end
    checkOutput("abandon delay no req/gnt", {31'd0, sawReq}, 32'd0);

    // Zero delay: mem_req_o one cycle after req_i, then abandon in ISSUE.
    cfgWrite(0, 0);
    applyStimulus(2'b01, 2'b00, {32'h0, 32'hE000_0000}, 64'd0);
    @(negedge clk);
    checkOutput("d0 latency1 mem_req", {31'd0, mem_req_o}, 32'd1);
    req_i = '0;
    #1;
    checkOutput("abandon issue gnt", {30'd0, gnt_o}, 32'd0);
    @(negedge clk);
    checkOutput("abandon issue mem_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("abandon issue busy", {31'd0, busy_o}, 32'd0);

    // Reset while waiting for the response.
    applyStimulus(2'b01, 2'b01, {32'h0, 32'hABCD_0000}, {32'h0, 32'h1234_5678});
    @(negedge clk);
    checkOutput("rstwait mem_req", {31'd0, mem_req_o}, 32'd1);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    req_i = '0;
    checkOutput("rstwait busy", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstwait busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rstwait mem_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("rstwait mem_we", {31'd0, mem_we_o}, 32'd0);
    checkOutput("rstwait mem_addr", mem_addr_o, 32'd0);
    checkOutput("rstwait mem_wdata", mem_wdata_o, 32'd0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h5555_AAAA;
    #1;
    checkOutput("rstwait stray rvalid", {30'd0, rvalid_o}, 32'd0);
    checkOutput("rstwait stray rdata", rdata_o, 32'd0);
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    checkOutput("rstwait stays idle", {31'd0, busy_o}, 32'd0);
    // Pointer back to 0 means requester 1 wins first; both delays back to 1.
    applyStimulus(2'b11, 2'b00, {32'hF000_0001, 32'hF000_0000}, 64'd0);
    doTxn("postrst r1", 1, 2, 32'hF000_0001, 1'b0, 32'h0, 32'h9, 1'b1);
    doTxn("postrst r0", 0, 2, 32'hF000_0000, 1'b0, 32'h0, 32'hA, 1'b1);
    req_i = '0;

`ifdef DELAY_ARB_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2'b01, 2'b00, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    checkOutput("stats mem_req", {31'd0, mem_req_o}, 32'd1);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    req_i = 2'b10;
    repeat (7) @(negedge clk);
    stat_sel_i = 1'b1;
    #1;
    checkOutput("stats blocked r1", stat_cnt_o, 32'd7);
    stat_sel_i = 1'b0;
    #1;
    checkOutput("stats r0", stat_cnt_o, 32'd2);
    req_i = '0;
    mem_rvalid_i = 1'b1;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
